// File: rtl/spi_sub_rx_if.sv
// spi_sub_rx_if: bundle of the SPI line inputs, the consumer acknowledge and
// the received-word outputs of spi_sub_rx.
//   master modport: drives sclk/mosi/csb/ack, observes the receiver outputs.
//   slave  modport: the receiver side (spi_sub_rx).
// Signals: sclk, mosi, csb (SPI, mode 0, csb active low), ack (consumer),
//   word_valid, word, pd, sample, pad, frame_err, overrun, busy (receiver).
interface spi_sub_rx_if #(
    parameter int WORD_WIDTH = 16,
    parameter int WAVE_W     = 12,
    parameter int PAD_W      = 2
);
    logic                  sclk;
    logic                  mosi;
    logic                  csb;
    logic                  ack;
    logic                  word_valid;
    logic [WORD_WIDTH-1:0] word;
    logic [1:0]            pd;
    logic [WAVE_W-1:0]     sample;
    logic [PAD_W-1:0]      pad;
    logic                  frame_err;
    logic                  overrun;
    logic                  busy;

    modport master (
        output sclk, mosi, csb, ack,
        input  word_valid, word, pd, sample, pad, frame_err, overrun, busy
    );

    modport slave (
        input  sclk, mosi, csb, ack,
        output word_valid, word, pd, sample, pad, frame_err, overrun, busy
    );
endinterface

// File: rtl/spi_sub_rx.sv
// spi_sub_rx: SPI subordinate receiver. Oversamples sclk/mosi/csb on sys_clk,
// deserializes MSB-first frames of WORD_WIDTH bits and presents each good
// word as {pd, sample, pad} through a valid/ack handshake.
// Ports:
//   sys_clk  system clock (rising edge)
//   rst      asynchronous active-high reset
//   bus      spi_sub_rx_if.slave: sclk, mosi, csb, ack in;
//            word_valid, word, pd, sample, pad, frame_err, overrun, busy out
module spi_sub_rx #(
    parameter int WORD_WIDTH  = 16,
    parameter int WAVE_W      = 12,
    parameter int PAD_W       = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic         sys_clk,
    input logic         rst,
    spi_sub_rx_if.slave bus
);
    localparam int CNT_W = $clog2(WORD_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_WIDTH + 1);

    generate
        if (WORD_WIDTH != 2 + WAVE_W + PAD_W) begin : g_bad_width
            $error("spi_sub_rx: WORD_WIDTH must equal 2+WAVE_W+PAD_W");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("spi_sub_rx: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csb_sync_q;
    logic                   sclk_q, csb_q;
    // settled_q[k] marks that sync stage k (and stage SYNC_STAGES = csb_q)
    // holds a real line sample rather than its reset value.
    logic [SYNC_STAGES:0]   settled_q;

    logic sclk_s, mosi_s, csb_s;
    logic sclk_rise, csb_fall, csb_rise;

    state_t                state_q;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      count_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  word_valid_q;
    logic                  frame_err_q;
    logic                  overrun_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csb_sync_q  <= '1;
            sclk_q      <= 1'b0;
            csb_q       <= 1'b1;
            settled_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], bus.csb};
            sclk_q      <= sclk_s;
            csb_q       <= csb_s;
            settled_q   <= {settled_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    // A falling csb is only believed once csb_q carries a real sample, so a
    // csb that was already low when reset released does not open a frame.
    assign csb_fall  = ~csb_s & csb_q & settled_q[SYNC_STAGES];
    assign csb_rise  = csb_s & ~csb_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            count_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (bus.ack) begin
                word_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (csb_fall) begin
                        shift_q <= '0;
                        count_q <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // csb rise takes priority; a coincident sclk edge is dropped.
                    if (csb_rise) begin
                        state_q <= IDLE;
                        if (count_q == CNT_FULL) begin
                            word_q       <= shift_q;
                            word_valid_q <= 1'b1;
                            if (word_valid_q && !bus.ack) begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[WORD_WIDTH-2:0], mosi_s};
                        // Saturating past WORD_WIDTH keeps an over-long frame bad.
                        if (count_q != CNT_SAT) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.word_valid = word_valid_q;
    assign bus.word       = word_q;
    assign bus.pd         = word_q[WORD_WIDTH-1:WORD_WIDTH-2];
    assign bus.sample     = word_q[WAVE_W+PAD_W-1:PAD_W];
    assign bus.pad        = word_q[PAD_W-1:0];
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = ~csb_s;
endmodule

// File: tb/tb_spi_sub_rx.sv
// tb_spi_sub_rx: self-checking bench for spi_sub_rx. SPI frames are driven at
// sclk = sys_clk/8; expected words go into a scoreboard queue when a frame is
// sent and are popped when the receiver raises word_valid.
module tb_spi_sub_rx;
    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    spi_sub_rx_if #(.WORD_WIDTH(16), .WAVE_W(12), .PAD_W(2)) bus ();

    spi_sub_rx #(
        .WORD_WIDTH (16),
        .WAVE_W     (12),
        .PAD_W      (2),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic frame_start();
        bus.csb = 1'b0;
        cyc(4);
    endtask

    task automatic shift_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.mosi = data[i];
            cyc(4);
            bus.sclk = 1'b1;
            cyc(4);
            bus.sclk = 1'b0;
        end
    endtask

    // Leaves csb freshly high at a falling sys_clk edge.
    task automatic frame_end();
        cyc(4);
        bus.csb = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] data, input int n);
        frame_start();
        shift_bits(data, n);
        frame_end();
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.word_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.word_valid, bus.word, bus.frame_err, bus.overrun, bus.busy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b word=%h err=%b ovr=%b busy=%b want all 0",
                     bus.word_valid, bus.word, bus.frame_err, bus.overrun, bus.busy);
        end
    endtask

    task automatic test_bad_frames();
        int errs;
        int vlds;
        for (int f = 0; f < 2; f++) begin
            errs = 0;
            vlds = 0;
            send_frame(32'h1_5A5A, (f == 0) ? 15 : 17);
            for (int i = 0; i < 10; i++) begin
                cyc(1);
                if (bus.frame_err === 1'b1) errs++;
                if (bus.word_valid === 1'b1) vlds++;
            end
            checks++;
            if (errs != 1) begin
                errors++;
                $display("FAIL bad_frame%0d_err_cycles: got %0d want 1", f, errs);
            end
            checks++;
            if (vlds != 0 || bus.word !== 16'h0) begin
                errors++;
                $display("FAIL bad_frame%0d_word: got vld_cycles=%0d word=%h want 0/0000", f, vlds, bus.word);
            end
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(16'hC7F3);
        send_frame(32'hC7F3, 16);
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            checks++;
            if (bus.word_valid !== (i == 3)) begin
                errors++;
                $display("FAIL basic_latency_edge%0d: got vld=%b want %b", i, bus.word_valid, (i == 3));
            end
        end
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.word !== exp_w || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_word: got %h err=%b want %h err=0", bus.word, bus.frame_err, exp_w);
        end
        checks++;
        if (bus.pd !== 2'b11 || bus.sample !== 12'h1FC || bus.pad !== 2'b11) begin
            errors++;
            $display("FAIL basic_fields: got pd=%b sample=%h pad=%b want 11/1fc/11", bus.pd, bus.sample, bus.pad);
        end
        pulse_ack();
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: got vld=%b want 0", bus.word_valid);
        end
    endtask

    task automatic test_handshake();
        bit ok;
        exp_q.push_back(16'h3FFF);
        send_frame(32'h3FFF, 16);
        wait_valid(ok);
        exp_w = exp_q.pop_front();
        checks++;
        if (!ok || bus.word !== exp_w || bus.sample !== 12'hFFF) begin
            errors++;
            $display("FAIL hs_first: got ok=%b word=%h sample=%h want 1/%h/fff", ok, bus.word, bus.sample, exp_w);
        end
        cyc(5);
        pulse_ack();
        checks++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL hs_ack_drop: got vld=%b ovr=%b want 0/0", bus.word_valid, bus.overrun);
        end
        exp_q.push_back(16'h0003);
        send_frame(32'h0003, 16);
        wait_valid(ok);
        exp_w = exp_q.pop_front();
        checks++;
        if (!ok || bus.word !== exp_w || bus.sample !== 12'h000 || bus.pad !== 2'b11 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL hs_second: got ok=%b word=%h sample=%h pad=%b ovr=%b want 1/%h/000/11/0",
                     ok, bus.word, bus.sample, bus.pad, bus.overrun, exp_w);
        end
        pulse_ack();
    endtask

    task automatic test_overrun();
        exp_q.push_back(16'h1234);
        send_frame(32'h1234, 16);
        cyc(3);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word !== exp_w || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got vld=%b word=%h ovr=%b want 1/%h/0", bus.word_valid, bus.word, bus.overrun, exp_w);
        end
        exp_q.push_back(16'hABCD);
        send_frame(32'hABCD, 16);
        cyc(3);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word !== exp_w || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second: got vld=%b word=%h ovr=%b want 1/%h/1", bus.word_valid, bus.word, bus.overrun, exp_w);
        end
        pulse_ack();
        checks++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ack_clear: got vld=%b ovr=%b want 0/0", bus.word_valid, bus.overrun);
        end
    endtask

    // A good frame completing on the same edge as ack keeps the new word valid.
    task automatic test_back_to_back();
        exp_q.push_back(16'h0F0F);
        send_frame(32'h0F0F, 16);
        cyc(3);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word !== exp_w) begin
            errors++;
            $display("FAIL b2b_first: got vld=%b word=%h want 1/%h", bus.word_valid, bus.word, exp_w);
        end
        exp_q.push_back(16'hF0F0);
        send_frame(32'hF0F0, 16);
        cyc(2);
        pulse_ack();
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word !== exp_w || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack_collide: got vld=%b word=%h ovr=%b want 1/%h/0",
                     bus.word_valid, bus.word, bus.overrun, exp_w);
        end
        pulse_ack();
    endtask

    task automatic test_reset_midframe();
        int errs;
        int vlds;
        bit ok;
        errs = 0;
        vlds = 0;
        frame_start();
        shift_bits(32'hFF, 8);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        shift_bits(32'hFF, 8);
        frame_end();
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.frame_err === 1'b1) errs++;
            if (bus.word_valid === 1'b1) vlds++;
        end
        checks++;
        if (errs != 0 || vlds != 0) begin
            errors++;
            $display("FAIL rstmid_no_event: got err_cycles=%0d vld_cycles=%0d want 0/0", errs, vlds);
        end
        checks++;
        if ({bus.word, bus.overrun, bus.busy} !== 18'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got word=%h ovr=%b busy=%b want 0", bus.word, bus.overrun, bus.busy);
        end
        exp_q.push_back(16'h5555);
        send_frame(32'h5555, 16);
        wait_valid(ok);
        exp_w = exp_q.pop_front();
        checks++;
        if (!ok || bus.word !== exp_w || bus.pd !== 2'b01 || bus.sample !== 12'h555 || bus.pad !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_next_frame: got ok=%b word=%h pd=%b sample=%h pad=%b want 1/%h/01/555/01",
                     ok, bus.word, bus.pd, bus.sample, bus.pad, exp_w);
        end
        pulse_ack();
    endtask

    task automatic test_zero_bit();
        int errs;
        int busys;
        int vlds;
        errs = 0;
        busys = 0;
        vlds = 0;
        bus.csb = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == 6) bus.csb = 1'b1;
            cyc(1);
            if (bus.frame_err === 1'b1) errs++;
            if (bus.busy === 1'b1) busys++;
            if (bus.word_valid === 1'b1) vlds++;
        end
        checks++;
        if (errs != 1) begin
            errors++;
            $display("FAIL zero_bit_err: got %0d cycles want 1", errs);
        end
        checks++;
        if (busys != 6 || vlds != 0) begin
            errors++;
            $display("FAIL zero_bit_busy: got busy_cycles=%0d vld_cycles=%0d want 6/0", busys, vlds);
        end
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.csb  = 1'b1;
        bus.ack  = 1'b0;
        cyc(3);
        test_reset();
        rst = 1'b0;
        cyc(4);
        test_bad_frames();
        test_basic();
        test_handshake();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_zero_bit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
